cp0_regfile_v2: RTL and testbench

Parametrised System Control Coprocessor (CP0) register file. It holds the non-MMU CP0 registers (BadVAddr, Count, Compare, Status, Cause, EPC, PRId) with per-bit write masks. It performs exception entry and ERET updates atomically and runs a Count/Compare timer. It also prioritises hardware interrupt lines into a registered interrupt request for the pipeline. MMU registers (rd 0–6, 10) are decoded and forwarded to the MMU, as the previous CP0 block did.

---
 rtl/cp0_pkg.sv | 65 ++++++
 rtl/cp0_timer.sv | 48 ++++
 rtl/cp0_regfile_v2.sv | 163 ++++++++++++++++
 tb/tb_cp0_regfile_v2.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, field positions, exception codes,
// software write masks and the MMU register selector encoding.
package cp0_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_ENTRYHI  = 5'd10;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;
    localparam logic [4:0] CP0_PRID     = 5'd15;

    localparam int ST_IE     = 0;
    localparam int ST_EXL    = 1;
    localparam int ST_IM_LO  = 8;
    localparam int CA_EXC_LO = 2;
    localparam int CA_IP_LO  = 8;
    localparam int CA_TI     = 30;
    localparam int CA_BD     = 31;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_MOD  = 5'd1;
    localparam logic [4:0] EXC_TLBL = 5'd2;
    localparam logic [4:0] EXC_TLBS = 5'd3;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
    localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;
    localparam logic [31:0] STATUS_RESET = 32'h0000_0002;

    localparam int MMU_REG_W = 4;

    typedef enum logic [MMU_REG_W-1:0] {
        MMU_NONE     = 4'd0,
        MMU_INDEX    = 4'd1,
        MMU_RANDOM   = 4'd2,
        MMU_ENTRYLO0 = 4'd3,
        MMU_ENTRYLO1 = 4'd4,
        MMU_CONTEXT  = 4'd5,
        MMU_PAGEMASK = 4'd6,
        MMU_WIRED    = 4'd7,
        MMU_ENTRYHI  = 4'd8
    } mmu_reg_e;

    function automatic mmu_reg_e mmu_decode(input logic [4:0] rd);
        case (rd)
            5'd0:        return MMU_INDEX;
            5'd1:        return MMU_RANDOM;
            5'd2:        return MMU_ENTRYLO0;
            5'd3:        return MMU_ENTRYLO1;
            5'd4:        return MMU_CONTEXT;
            5'd5:        return MMU_PAGEMASK;
            5'd6:        return MMU_WIRED;
            CP0_ENTRYHI: return MMU_ENTRYHI;
            default:     return MMU_NONE;
        endcase
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: prescaler, free-running Count, Compare and the TI flag.
// Instantiated by cp0_regfile_v2 only when CP0_TIMER_EN is defined.
module cp0_timer #(
    parameter int unsigned COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    localparam int unsigned PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(COUNT_DIV - 1);

    logic [PW-1:0] presc;
    logic          tick;
    logic [31:0]   count_inc;

    assign tick      = (presc == PRESC_MAX);
    assign count_inc = count + 32'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            presc   <= '0;
            count   <= '0;
            compare <= '0;
            ti      <= 1'b0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (count_we)
                count <= wdata;
            else if (tick)
                count <= count_inc;
            if (compare_we)
                compare <= wdata;
            // A Compare write acknowledges the timer even when it coincides with a match.
            if (compare_we)
                ti <= 1'b0;
            else if (tick && !count_we && count_inc == compare)
                ti <= 1'b1;
        end
    end

endmodule

// File: rtl/cp0_regfile_v2.sv
// CP0 register file: local registers, exception/ERET updates, interrupt request,
// MMU register forwarding. Define CP0_TIMER_EN to include the Count/Compare timer.
module cp0_regfile_v2
    import cp0_pkg::*;
#(
    parameter int unsigned NUM_HW_INT = 6,
    parameter int unsigned COUNT_DIV  = 2,
    parameter logic [31:0] PRID       = 32'h0001_8000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  re,
    input  logic [4:0]            rd,
    input  logic [2:0]            sel,
    input  logic [31:0]           data_in,
    output logic [31:0]           data_out,
    input  logic [31:0]           mmu_data_out,
    output logic [31:0]           mmu_data_in,
    output mmu_reg_e              mmu_reg,
    output logic                  mmu_read,
    output logic                  mmu_write,
    input  logic                  exc_valid,
    input  logic [4:0]            exc_code,
    input  logic [31:0]           exc_epc,
    input  logic                  exc_bd,
    input  logic [31:0]           exc_badvaddr,
    input  logic                  exc_badvaddr_we,
    input  logic                  eret,
    input  logic [NUM_HW_INT-1:0] hw_int,
    output logic                  int_pending,
    output logic [31:0]           epc,
    output logic [31:0]           status,
    output logic [31:0]           cause
);

    if (NUM_HW_INT < 1 || NUM_HW_INT > 6) begin : g_bad_hw_int
        $error("NUM_HW_INT must be in 1..6");
    end
    if (COUNT_DIV < 1) begin : g_bad_count_div
        $error("COUNT_DIV must be at least 1");
    end

    logic        sel0;
    logic        is_mmu;
    logic        wr_local, wr_status, wr_cause, wr_epc;
    logic [31:0] badvaddr;
    logic [7:0]  im;
    logic        exl, ie;
    logic        bd;
    logic [4:0]  excode;
    logic [1:0]  ip_sw;
    logic [5:0]  ip_hw;
    logic [5:0]  hw_pad;
    logic [5:0]  ip_hi;
    logic        irq_hit;
    logic [31:0] rdata;
    logic [31:0] timer_count, timer_compare;
    logic        timer_ti;

    assign sel0        = (sel == 3'd0);
    assign mmu_reg     = sel0 ? mmu_decode(rd) : MMU_NONE;
    assign is_mmu      = (mmu_reg != MMU_NONE);
    assign mmu_read    = re & is_mmu;
    assign mmu_write   = we & is_mmu;
    assign mmu_data_in = data_in;

    assign wr_local  = we & sel0;
    assign wr_status = wr_local & (rd == CP0_STATUS);
    assign wr_cause  = wr_local & (rd == CP0_CAUSE);
    assign wr_epc    = wr_local & (rd == CP0_EPC);

`ifdef CP0_TIMER_EN
    cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (wr_local & (rd == CP0_COUNT)),
        .compare_we (wr_local & (rd == CP0_COMPARE)),
        .wdata      (data_in),
        .count      (timer_count),
        .compare    (timer_compare),
        .ti         (timer_ti)
    );
`else
    assign timer_count   = '0;
    assign timer_compare = '0;
    assign timer_ti      = 1'b0;
`endif

    always_comb begin
        hw_pad = '0;
        hw_pad[NUM_HW_INT-1:0] = hw_int;
    end

    // The timer shares IP7 with the last hardware line.
    assign ip_hi   = {ip_hw[5] | timer_ti, ip_hw[4:0]};
    assign status  = {16'b0, im, 6'b0, exl, ie};
    assign cause   = {bd, timer_ti, 14'b0, ip_hi, ip_sw, 1'b0, excode, 2'b0};
    assign irq_hit = |(cause[15:8] & im);

    // NOTE: rdata gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        rdata = '0;
        if (is_mmu) begin
            rdata = mmu_data_out;
        end else if (sel0) begin
            case (rd)
                CP0_BADVADDR: rdata = badvaddr;
                CP0_COUNT:    rdata = timer_count;
                CP0_COMPARE:  rdata = timer_compare;
                CP0_STATUS:   rdata = status;
                CP0_CAUSE:    rdata = cause;
                CP0_EPC:      rdata = epc;
                CP0_PRID:     rdata = PRID;
                default:      rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            badvaddr    <= '0;
            epc         <= '0;
            im          <= '0;
            exl         <= STATUS_RESET[ST_EXL];
            ie          <= STATUS_RESET[ST_IE];
            bd          <= 1'b0;
            excode      <= '0;
            ip_sw       <= '0;
            ip_hw       <= '0;
            int_pending <= 1'b0;
            data_out    <= '0;
        end else begin
            ip_hw       <= hw_pad;
            int_pending <= !exc_valid && ie && !exl && irq_hit;
            if (re)
                data_out <= rdata;
            if (wr_status) begin
                im  <= data_in[ST_IM_LO +: 8];
                exl <= data_in[ST_EXL];
                ie  <= data_in[ST_IE];
            end
            if (wr_cause)
                ip_sw <= data_in[CA_IP_LO +: 2];
            if (wr_epc && !exc_valid)
                epc <= data_in;
            // NOTE: a later non-blocking assignment to the same field wins, giving exc_valid > eret > mtc0.
            if (eret)
                exl <= 1'b0;
            if (exc_valid) begin
                exl    <= 1'b1;
                excode <= exc_code;
                if (!exl) begin
                    epc <= exc_epc;
                    bd  <= exc_bd;
                end
                if (exc_badvaddr_we)
                    badvaddr <= exc_badvaddr;
            end
        end
    end

endmodule

// File: tb/tb_cp0_regfile_v2.sv
// Self-checking bench for cp0_regfile_v2: directed scenarios plus randomized traffic
// compared each cycle against a word-level reference model of the CP0 rules.
module tb_cp0_regfile_v2;
    import cp0_pkg::*;

    localparam int unsigned NUM_HW_INT = 6;
    localparam int unsigned COUNT_DIV  = 2;
    localparam logic [31:0] PRID       = 32'h0001_8000;
`ifdef CP0_TIMER_EN
    localparam bit TIMER_EN = 1'b1;
`else
    localparam bit TIMER_EN = 1'b0;
`endif

    logic                  clk;
    logic                  rst, we, re;
    logic [4:0]            rd;
    logic [2:0]            sel;
    logic [31:0]           data_in, data_out, mmu_data_out, mmu_data_in;
    mmu_reg_e              mmu_reg;
    logic                  mmu_read, mmu_write;
    logic                  exc_valid, exc_bd, exc_badvaddr_we, eret;
    logic [4:0]            exc_code;
    logic [31:0]           exc_epc, exc_badvaddr;
    logic [NUM_HW_INT-1:0] hw_int;
    logic                  int_pending;
    logic [31:0]           epc, status, cause;

    cp0_regfile_v2 #(.NUM_HW_INT(NUM_HW_INT), .COUNT_DIV(COUNT_DIV), .PRID(PRID)) dut (
        .clk(clk), .rst(rst), .we(we), .re(re), .rd(rd), .sel(sel),
        .data_in(data_in), .data_out(data_out),
        .mmu_data_out(mmu_data_out), .mmu_data_in(mmu_data_in),
        .mmu_reg(mmu_reg), .mmu_read(mmu_read), .mmu_write(mmu_write),
        .exc_valid(exc_valid), .exc_code(exc_code), .exc_epc(exc_epc), .exc_bd(exc_bd),
        .exc_badvaddr(exc_badvaddr), .exc_badvaddr_we(exc_badvaddr_we),
        .eret(eret), .hw_int(hw_int), .int_pending(int_pending),
        .epc(epc), .status(status), .cause(cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference model: architectural words plus the timer state.
    logic [31:0] m_status, m_cause, m_epc, m_badv, m_count, m_compare, m_dout;
    logic [5:0]  m_ip;
    logic        m_ti, m_pend;
    int unsigned m_presc;

    function automatic bit is_mmu_rd(input logic [4:0] r);
        return (r <= 5'd6) || (r == 5'd10);
    endfunction

    function automatic mmu_reg_e exp_mmu(input logic [4:0] r, input logic [2:0] s);
        if (s != 3'd0) return MMU_NONE;
        case (r)
            5'd0:    return MMU_INDEX;
            5'd1:    return MMU_RANDOM;
            5'd2:    return MMU_ENTRYLO0;
            5'd3:    return MMU_ENTRYLO1;
            5'd4:    return MMU_CONTEXT;
            5'd5:    return MMU_PAGEMASK;
            5'd6:    return MMU_WIRED;
            5'd10:   return MMU_ENTRYHI;
            default: return MMU_NONE;
        endcase
    endfunction

    function automatic logic [31:0] m_cause_rd();
        return m_cause | (32'(m_ip) << 10) | (m_ti ? 32'h4000_8000 : 32'h0);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] r, input logic [2:0] s);
        if (s != 3'd0) return 32'h0;
        if (is_mmu_rd(r)) return mmu_data_out;
        case (r)
            5'd8:    return m_badv;
            5'd9:    return TIMER_EN ? m_count : 32'h0;
            5'd11:   return TIMER_EN ? m_compare : 32'h0;
            5'd12:   return m_status;
            5'd13:   return m_cause_rd();
            5'd14:   return m_epc;
            5'd15:   return PRID;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_status = 32'h0000_0002;
        m_cause = 0; m_epc = 0; m_badv = 0; m_count = 0; m_compare = 0; m_dout = 0;
        m_ip = 0; m_ti = 0; m_pend = 0; m_presc = 0;
    endtask

    task automatic model_edge();
        logic [31:0] rv, cr;
        logic        old_exl, wl, pend_n, tick;
        if (rst) begin
            model_reset();
            return;
        end
        rv      = m_read(rd, sel);
        cr      = m_cause_rd();
        pend_n  = !exc_valid && m_status[0] && !m_status[1] && (|(cr[15:8] & m_status[15:8]));
        old_exl = m_status[1];
        wl      = we && (sel == 3'd0);
        if (wl && rd == 5'd12) m_status = (m_status & ~32'h0000_FF03) | (data_in & 32'h0000_FF03);
        if (eret) m_status[1] = 1'b0;
        if (exc_valid) m_status[1] = 1'b1;
        if (wl && rd == 5'd13) m_cause[9:8] = data_in[9:8];
        if (exc_valid) begin
            m_cause[6:2] = exc_code;
            if (!old_exl) begin
                m_cause[31] = exc_bd;
                m_epc = exc_epc;
            end
            if (exc_badvaddr_we) m_badv = exc_badvaddr;
        end else if (wl && rd == 5'd14) begin
            m_epc = data_in;
        end
        m_ip = 0;
        for (int i = 0; i < NUM_HW_INT; i++) m_ip[i] = hw_int[i];
        if (TIMER_EN) begin
            tick = (m_presc == COUNT_DIV - 1);
            m_presc = tick ? 0 : m_presc + 1;
            if (wl && rd == 5'd9) m_count = data_in;
            else if (tick) begin
                m_count = m_count + 1;
                if (m_count == m_compare) m_ti = 1'b1;
            end
            if (wl && rd == 5'd11) begin
                m_compare = data_in;
                m_ti = 1'b0;
            end
        end
        if (re) m_dout = rv;
        m_pend = pend_n;
    endtask

    task automatic step();
        #1;
        check("mmu_reg",     32'(mmu_reg),     32'(exp_mmu(rd, sel)));
        check("mmu_read",    32'(mmu_read),    32'(re && exp_mmu(rd, sel) != MMU_NONE));
        check("mmu_write",   32'(mmu_write),   32'(we && exp_mmu(rd, sel) != MMU_NONE));
        check("mmu_data_in", mmu_data_in,      data_in);
        @(posedge clk);
        model_edge();
        #1;
        check("data_out",    data_out,         m_dout);
        check("int_pending", 32'(int_pending), 32'(m_pend));
        check("status",      status,           m_status);
        check("cause",       cause,            m_cause_rd());
        check("epc",         epc,              m_epc);
    endtask

    task automatic idle();
        rst = 0; we = 0; re = 0; rd = 0; sel = 0; data_in = 0;
        exc_valid = 0; exc_code = 0; exc_epc = 0; exc_bd = 0;
        exc_badvaddr = 0; exc_badvaddr_we = 0; eret = 0;
    endtask

    task automatic mtc0(input logic [4:0] r, input logic [2:0] s, input logic [31:0] d);
        idle(); we = 1; rd = r; sel = s; data_in = d;
        step();
        idle();
    endtask

    task automatic mfc0(input logic [4:0] r, input logic [2:0] s, output logic [31:0] v);
        idle(); re = 1; rd = r; sel = s;
        step();
        v = data_out;
        idle();
    endtask

    task automatic take_exc(input logic [31:0] pc, input logic b, input logic [4:0] code,
                            input logic [31:0] bva, input logic bvwe);
        idle(); exc_valid = 1; exc_epc = pc; exc_bd = b; exc_code = code;
        exc_badvaddr = bva; exc_badvaddr_we = bvwe;
        step();
        idle();
    endtask

    initial begin
        logic [31:0] v;
        bit          found;
        model_reset();
        idle();
        hw_int = '0;
        mmu_data_out = 32'hA5A5_0001;
        rst = 1;
        step();
        step();
        rst = 0;
        check("rst_data_out", data_out, 32'h0);
        check("rst_int_pending", 32'(int_pending), 32'h0);

        mfc0(5'd12, 3'd0, v); check("rd_status_reset", v, 32'h0000_0002);
        mfc0(5'd15, 3'd0, v); check("rd_prid", v, PRID);
        mfc0(5'd12, 3'd1, v); check("rd_sel1", v, 32'h0);

        mtc0(5'd12, 3'd0, 32'hFFFF_FFFF);
        mfc0(5'd12, 3'd0, v); check("status_mask", v, 32'h0000_FF03);
        mtc0(5'd13, 3'd0, 32'hFFFF_FFFF);
        mfc0(5'd13, 3'd0, v); check("cause_mask", v, 32'h0000_0300);
        mtc0(5'd8, 3'd0, 32'hFFFF_FFFF);
        mfc0(5'd8, 3'd0, v); check("badvaddr_ro", v, 32'h0);

        mtc0(5'd12, 3'd0, 32'h0);
        mtc0(5'd13, 3'd0, 32'h0);
        take_exc(32'h8000_0100, 1'b1, EXC_ADEL, 32'h0000_1234, 1'b1);
        check("exc_exl", status, 32'h0000_0002);
        mfc0(5'd14, 3'd0, v); check("exc_epc", v, 32'h8000_0100);
        mfc0(5'd13, 3'd0, v); check("exc_cause", v, 32'h8000_0010);
        mfc0(5'd8, 3'd0, v);  check("exc_badvaddr", v, 32'h0000_1234);
        take_exc(32'h0000_0200, 1'b0, EXC_ADES, 32'h0, 1'b0);
        mfc0(5'd14, 3'd0, v); check("nested_epc_held", v, 32'h8000_0100);
        check("nested_bd_held", 32'(cause[31]), 32'h1);
        idle(); eret = 1; step(); idle();
        check("eret_exl", 32'(status[1]), 32'h0);

        hw_int = 6'b000001;
        mtc0(5'd12, 3'd0, 32'h0000_0401);
        step();
        check("int_pending_set", 32'(int_pending), 32'h1);
        take_exc(32'h0000_0300, 1'b0, EXC_INT, 32'h0, 1'b0);
        check("int_pending_clr", 32'(int_pending), 32'h0);
        hw_int = '0;

`ifdef CP0_TIMER_EN
        mtc0(5'd11, 3'd0, 32'd10);
        mtc0(5'd9, 3'd0, 32'd0);
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            step();
            if (cause[30]) found = 1;
        end
        check("ti_set", 32'(found), 32'h1);
        check("ip7_set", 32'(cause[15]), 32'h1);
        mtc0(5'd11, 3'd0, 32'd10);
        check("ti_clear", 32'(cause[30]), 32'h0);
        mtc0(5'd9, 3'd0, 32'hFFFF_FFFF);
        step();
        step();
        mfc0(5'd9, 3'd0, v); check("count_wrap", v, 32'h0);
`else
        mtc0(5'd9, 3'd0, 32'd5);
        mfc0(5'd9, 3'd0, v);  check("count_absent", v, 32'h0);
        mtc0(5'd11, 3'd0, 32'd7);
        mfc0(5'd11, 3'd0, v); check("compare_absent", v, 32'h0);
        check("ti_absent", 32'(cause[30]), 32'h0);
`endif

        mtc0(5'd12, 3'd0, 32'h0000_0001);
        idle(); we = 1; rd = 5'd12; data_in = 32'h0; exc_valid = 1; exc_epc = 32'h400; eret = 1;
        step(); idle();
        check("prio_status", status, 32'h0000_0002);

        mmu_data_out = 32'hDEAD_BEEF;
        idle(); re = 1; rd = 5'd2;
        #1;
        check("mmu_rd2_read", 32'(mmu_read), 32'h1);
        step(); idle();
        check("mmu_rd2_data", data_out, 32'hDEAD_BEEF);

        for (int n = 0; n < 1500; n++) begin
            rst       = ($urandom_range(0, 199) == 0);
            we        = ($urandom_range(0, 3) == 0);
            re        = ($urandom_range(0, 1) == 1);
            rd        = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 15));
            sel       = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            data_in   = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
            exc_valid = ($urandom_range(0, 11) == 0);
            eret      = ($urandom_range(0, 11) == 0);
            exc_code  = 5'($urandom);
            exc_epc   = $urandom;
            exc_bd    = ($urandom_range(0, 1) == 1);
            exc_badvaddr    = $urandom;
            exc_badvaddr_we = ($urandom_range(0, 1) == 1);
            mmu_data_out    = $urandom;
            if (n % 8 == 0) hw_int = NUM_HW_INT'($urandom);
            step();
        end
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
